inst_fetch: RTL

Instruction fetch stage sitting directly upstream of instruction decode. Holds the PC and issues in-order requests to instruction memory, which may have variable latency. Buffers up to two returned instructions and presents one `inst`/`inst_addr` pair per cycle to decode. Honours decode's pause signal and redirects on a jump from execute, discarding any in-flight stale responses.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/inst_fetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants, payload types and helpers for the instruction fetch stage.
package inst_fetch_pkg;

   localparam int unsigned XLEN_WIDTH = 32;
   localparam logic [XLEN_WIDTH-1:0] INST_NOP = 32'h0000_0013;
   localparam logic [XLEN_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered instruction paired with the address it was fetched from.
   typedef struct packed {
      logic [XLEN_WIDTH-1:0] addr;
      logic [XLEN_WIDTH-1:0] data;
   } fetch_entry_t;

   localparam int unsigned ENTRY_WIDTH = $bits(fetch_entry_t);

   // Force an address onto a word boundary.
   function automatic logic [XLEN_WIDTH-1:0] align_word(input logic [XLEN_WIDTH-1:0] a);
      return a & ~XLEN_WIDTH'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush; head entry is visible on rdata.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy; clear drops every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (clear) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited memory requests, response pairing,
// two-entry output buffer and jump redirect with stale-response dropping.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [XLEN_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_req,
   output logic [XLEN_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [XLEN_WIDTH-1:0] mem_rdata,
   input  logic                  pause,
   input  logic                  jump_flag,
   input  logic [XLEN_WIDTH-1:0] jump_addr,
   output logic [XLEN_WIDTH-1:0] inst,
   output logic [XLEN_WIDTH-1:0] inst_addr,
   output logic                  inst_valid
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state;
   logic [XLEN_WIDTH-1:0] pc;
   logic [1:0]            drop_cnt;

   logic [XLEN_WIDTH-1:0] aq_head;
   logic                  aq_full;
   logic                  aq_empty;
   logic [1:0]            aq_count;

   fetch_entry_t          buf_head;
   fetch_entry_t          buf_wdata;
   logic                  buf_full;
   logic                  buf_empty;
   logic [1:0]            buf_count;

   logic                  grant;
   logic                  rsp;
   logic                  pop;
   logic                  credit;
   logic                  buf_push;
   logic [1:0]            jump_drop;

   // Handshakes; responses with nothing outstanding are ignored.
   assign grant = mem_req && mem_gnt;
   assign rsp   = mem_rvalid && !aq_empty;
   assign pop   = inst_valid && !pause;

   // At most two instructions in flight or buffered, counting this cycle's pop.
   assign credit  = (3'(aq_count) + 3'(buf_count) - 3'(pop)) < 3'd2;
   assign mem_req  = (state == RUN) && credit && !jump_flag;
   assign mem_addr = pc;

   // Responses land in the buffer only while running and not redirecting.
   assign buf_push  = rsp && (state == RUN) && !jump_flag;
   assign buf_wdata = '{addr: aq_head, data: mem_rdata};
   assign jump_drop = aq_count - 2'(rsp);

   assign inst_valid = !buf_empty;
   assign inst       = buf_empty ? INST_NOP : buf_head.data;
   assign inst_addr  = buf_empty ? '0 : buf_head.addr;

   // Addresses of granted requests, consumed by responses in grant order.
   fetch_fifo #(.WIDTH(XLEN_WIDTH)) u_addr_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .pop   (rsp),
      .clear (1'b0),
      .wdata (pc),
      .rdata (aq_head),
      .full  (aq_full),
      .empty (aq_empty),
      .count (aq_count)
   );

   // Instruction/address pairs waiting for decode.
   fetch_fifo #(.WIDTH(ENTRY_WIDTH)) u_out_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (buf_push),
      .pop   (pop),
      .clear (jump_flag),
      .wdata (buf_wdata),
      .rdata (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   // Fetch state, PC and stale-response drop counter; jump has top priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         drop_cnt <= 2'd0;
      end else if (jump_flag) begin
         pc       <= align_word(jump_addr);
         drop_cnt <= jump_drop;
         state    <= (jump_drop != 2'd0) ? FLUSH : RUN;
      end else begin
         case (state)
            IDLE: state <= RUN;
            RUN: begin
               if (grant) pc <= pc + XLEN_WIDTH'(4);
            end
            FLUSH: begin
               if (drop_cnt == 2'd0) begin
                  state <= RUN;
               end else if (rsp) begin
                  drop_cnt <= drop_cnt - 2'd1;
                  if (drop_cnt == 2'd1) state <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory protocol and credit sanity.
   assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid |-> !aq_empty);
   assert property (@(posedge clk) disable iff (!rst_n) grant |-> (!aq_full || rsp));
   assert property (@(posedge clk) disable iff (!rst_n) buf_push |-> (!buf_full || pop));

endmodule
